com_sdp_stream_fifo: RTL and testbench



---
 rtl/com_sdp_stream_fifo_pkg.sv | 13 +
 rtl/com_simple_dual_port_ram.sv | 50 +++++
 rtl/com_sdp_stream_fifo.sv | 133 +++++++++++++
 tb/tb_com_sdp_stream_fifo.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/com_sdp_stream_fifo_pkg.sv
// ---------------------------------------------------------------------------
// com_sdp_stream_fifo_pkg
// Shared constants for the stream FIFO built around the simple dual-port RAM.
// The output queue in front of the RAM read port holds at most two words
// (head and skid); these names give its occupancy values readable labels.
// ---------------------------------------------------------------------------
package com_sdp_stream_fifo_pkg;

   localparam logic [1:0] OQ_EMPTY = 2'd0;
   localparam logic [1:0] OQ_ONE   = 2'd1;
   localparam logic [1:0] OQ_FULL  = 2'd2;

endpackage

// File: rtl/com_simple_dual_port_ram.sv
// ---------------------------------------------------------------------------
// com_simple_dual_port_ram
// Simple dual-port RAM: port A writes, port B reads with one cycle of latency.
// Ports:
//   clk           clock
//   en_a, we_a    port A enable / write enable
//   addr_a, din_a port A address / write data
//   en_b          port B read enable
//   addr_b        port B read address
//   dout_b        port B read data, valid the cycle after addr_b is presented
// RAM_STYLE_VAL steers the synthesis mapping of the storage array.
// ---------------------------------------------------------------------------
module com_simple_dual_port_ram #(
   parameter int    WIDTH         = 72,
   parameter int    ADDR_BIT      = 9,
   parameter int    DEPTH         = 2 ** ADDR_BIT,
   parameter string RAM_STYLE_VAL = "block"
) (
   input  logic                clk,
   input  logic                en_a,
   input  logic                we_a,
   input  logic [ADDR_BIT-1:0] addr_a,
   input  logic [WIDTH-1:0]    din_a,
   input  logic                en_b,
   input  logic [ADDR_BIT-1:0] addr_b,
   output logic [WIDTH-1:0]    dout_b
);

   if (RAM_STYLE_VAL == "distributed") begin : g_lut
      (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

      // NOTE: the storage array has no reset; clearing every word would
      // prevent mapping onto RAM primitives, and the owner never reads an
      // entry it has not written.
      always_ff @(posedge clk) begin
         // NOTE: non-blocking assignments for all clocked state, so every
         // register samples its inputs from before the edge.
         if (en_a && we_a) mem[addr_a] <= din_a;
         if (en_b)         dout_b      <= mem[addr_b];
      end
   end else begin : g_blk
      (* ram_style = RAM_STYLE_VAL *) logic [WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
         if (en_a && we_a) mem[addr_a] <= din_a;
         if (en_b)         dout_b      <= mem[addr_b];
      end
   end

endmodule

// File: rtl/com_sdp_stream_fifo.sv
// ---------------------------------------------------------------------------
// com_sdp_stream_fifo
// Valid/ready stream FIFO with first-word-fall-through output, built on a
// simple dual-port RAM plus a two-entry register queue (head + skid) that
// hides the RAM read latency and sustains one word per cycle.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr          synchronous flush (lower priority than rst_n)
//   in_valid     upstream word valid
//   in_ready     FIFO can accept (registered)
//   in_data      upstream word
//   out_valid    head word valid (registered)
//   out_ready    downstream accepts head word
//   out_data     head word (registered)
//   count        RAM entries + reads in flight + output-queue entries
//   almost_full  count >= AF_LEVEL (registered)
// ---------------------------------------------------------------------------
module com_sdp_stream_fifo #(
   parameter int    WIDTH         = 72,
   parameter int    ADDR_BIT      = 9,
   parameter int    AF_LEVEL      = 448,
   parameter string RAM_STYLE_VAL = "block"
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic [ADDR_BIT+1:0] count,
   output logic                almost_full
);
   import com_sdp_stream_fifo_pkg::*;

   localparam int DEPTH = 2 ** ADDR_BIT;
   localparam int PTR_W = ADDR_BIT + 1;
   localparam int CNT_W = ADDR_BIT + 2;

   // Pointers carry one extra bit so that full (difference = DEPTH) and
   // empty (difference = 0) are distinguishable.
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
   logic [PTR_W-1:0] ram_cnt, ram_cnt_next;
   logic [1:0]       oq_cnt, oq_cnt_next;
   logic             rd_pend;
   logic             push, pop, issue;
   logic [WIDTH-1:0] skid, skid_next, head_next, dout_b;
   logic [CNT_W-1:0] count_next;

   com_simple_dual_port_ram #(
      .WIDTH         (WIDTH),
      .ADDR_BIT      (ADDR_BIT),
      .DEPTH         (DEPTH),
      .RAM_STYLE_VAL (RAM_STYLE_VAL)
   ) u_ram (
      .clk    (clk),
      .en_a   (push),
      .we_a   (push),
      .addr_a (wr_ptr[ADDR_BIT-1:0]),
      .din_a  (in_data),
      .en_b   (1'b1),
      .addr_b (rd_ptr[ADDR_BIT-1:0]),
      .dout_b (dout_b)
   );

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      push         = in_valid && in_ready && !clr;
      pop          = out_valid && out_ready && !clr;
      ram_cnt      = wr_ptr - rd_ptr;
      // Queue occupancy after this edge: the pending read lands, the pop leaves.
      oq_cnt_next  = oq_cnt + {1'b0, rd_pend} - {1'b0, pop};
      // Issue only if the word can still find a slot when it lands next cycle.
      issue        = (ram_cnt != '0) && (oq_cnt_next <= OQ_ONE);
      wr_ptr_next  = wr_ptr + PTR_W'(push);
      rd_ptr_next  = rd_ptr + PTR_W'(issue);
      ram_cnt_next = wr_ptr_next - rd_ptr_next;
      count_next   = CNT_W'(ram_cnt_next) + CNT_W'(issue) + CNT_W'(oq_cnt_next);
   end

   // Output queue data path: a pop shifts skid into head, and the landing
   // read word fills the first free slot after that shift.
   always_comb begin
      head_next = out_data;
      skid_next = skid;
      if (pop) begin
         if (oq_cnt == OQ_FULL) begin
            head_next = skid;
            if (rd_pend) skid_next = dout_b;
         end else if (rd_pend) begin
            head_next = dout_b;
         end
      end else if (rd_pend) begin
         if (oq_cnt == OQ_EMPTY) head_next = dout_b;
         else                    skid_next = dout_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rd_pend     <= 1'b0;
         oq_cnt      <= OQ_EMPTY;
         out_valid   <= 1'b0;
         out_data    <= '0;
         count       <= '0;
         almost_full <= 1'b0;
         // Held low through reset; a flush leaves the FIFO empty and open.
         in_ready    <= rst_n;
      end else begin
         wr_ptr      <= wr_ptr_next;
         rd_ptr      <= rd_ptr_next;
         rd_pend     <= issue;
         oq_cnt      <= oq_cnt_next;
         out_valid   <= (oq_cnt_next != OQ_EMPTY);
         out_data    <= head_next;
         count       <= count_next;
         almost_full <= (count_next >= CNT_W'(AF_LEVEL));
         in_ready    <= (ram_cnt_next < PTR_W'(DEPTH));
      end
   end

   // Skid contents are only meaningful while oq_cnt says so.
   always_ff @(posedge clk) begin
      skid <= skid_next;
   end

endmodule

// File: tb/tb_com_sdp_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_com_sdp_stream_fifo
// Self-checking bench for com_sdp_stream_fifo (ADDR_BIT = 4, depth 16).
// The reference model is a queue of accepted words tagged with the cycle of
// their handshake: occupancy is its size, order is its order, and a word at
// the head is visible three cycles after its handshake.
// ---------------------------------------------------------------------------
module tb_com_sdp_stream_fifo;

   localparam int WIDTH    = 16;
   localparam int ADDR_BIT = 4;
   localparam int DEPTH    = 16;
   localparam int AF_LEVEL = 12;
   localparam int CAP      = DEPTH + 2;
   localparam int CNT_W    = ADDR_BIT + 2;

   logic             clk = 1'b0;
   logic             rst_n, clr, in_valid, in_ready, out_valid, out_ready, almost_full;
   logic [WIDTH-1:0] in_data, out_data;
   logic [CNT_W-1:0] count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [WIDTH-1:0] q_data[$];
   int               q_time[$];

   logic             last_push, last_pop;
   logic [WIDTH-1:0] pop_act, pop_exp;
   int               step_cyc;

   com_sdp_stream_fifo #(
      .WIDTH         (WIDTH),
      .ADDR_BIT      (ADDR_BIT),
      .AF_LEVEL      (AF_LEVEL),
      .RAM_STYLE_VAL ("block")
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .count       (count),
      .almost_full (almost_full)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
      $fatal(1, "simulation time limit");
   end

   // One clock cycle: drive inputs, note the handshakes the DUT will see at
   // the coming edge, advance, then update the model. Called #1 after an edge.
   task automatic step(input logic v, input logic [WIDTH-1:0] d,
                       input logic r, input logic c);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      clr       = c;
      step_cyc  = cyc;
      last_push = v && in_ready && !c;
      last_pop  = out_valid && r && !c;
      pop_act   = out_data;
      pop_exp   = (q_data.size() > 0) ? q_data[0] : 'x;
      @(posedge clk);
      #1;
      if (c) begin
         q_data.delete();
         q_time.delete();
      end else begin
         if (last_pop && q_data.size() > 0) begin
            void'(q_data.pop_front());
            void'(q_time.pop_front());
         end
         if (last_push) begin
            q_data.push_back(d);
            q_time.push_back(step_cyc);
         end
      end
      cyc++;
   endtask

   // Pops until the model is empty; reports how many words came out and how
   // many differed from the model.
   task automatic drain(input int budget, output int n_pop, output int n_bad);
      n_pop = 0;
      n_bad = 0;
      for (int k = 0; k < budget && q_data.size() > 0; k++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         if (last_pop) begin
            n_pop++;
            if (pop_act !== pop_exp) n_bad++;
         end
      end
   endtask

   task automatic wait_valid(input int budget, output logic ok);
      ok = out_valid;
      for (int k = 0; k < budget && !ok; k++) begin
         step(1'b0, '0, 1'b0, 1'b0);
         ok = out_valid;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
      checks++; if (count !== '0) begin errors++; $display("FAIL release_count: got %0d want 0", count); end
      q_data.delete();
      q_time.delete();
      cyc = 0;
   endtask

   task automatic test_first_word();
      step(1'b1, 16'h00A5, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         checks++;
         if (out_valid !== (i == 3)) begin
            errors++; $display("FAIL latency_out_valid cycle %0d: got %b want %b", i, out_valid, (i == 3));
         end
         if (i < 3) step(1'b0, '0, 1'b0, 1'b0);
      end
      checks++; if (out_data !== 16'h00A5) begin errors++; $display("FAIL latency_out_data: got %h want 00a5", out_data); end
      checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL latency_count: got %0d want 1", count); end
      step(1'b0, '0, 1'b1, 1'b0);
      checks++; if (!last_pop || pop_act !== 16'h00A5) begin errors++; $display("FAIL latency_pop: popped %b data %h want 00a5", last_pop, pop_act); end
      checks++; if (count !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL latency_empty: count %0d valid %b want 0/0", count, out_valid); end
   endtask

   task automatic test_streaming();
      int in_idx = 0, out_idx = 0, first_pop = -1, last_pop_cyc = -1, start = cyc;
      for (int k = 0; k < 1100 && out_idx < 1000; k++) begin
         step(in_idx < 1000, WIDTH'(in_idx), 1'b1, 1'b0);
         if (last_push) in_idx++;
         if (last_pop) begin
            checks++;
            if (pop_act !== WIDTH'(out_idx)) begin
               errors++; $display("FAIL stream_data: got %0d want %0d", pop_act, out_idx);
            end
            if (first_pop < 0) first_pop = step_cyc;
            last_pop_cyc = step_cyc;
            out_idx++;
         end
         checks++;
         if (count > CNT_W'(3) || count !== CNT_W'(q_data.size())) begin
            errors++; $display("FAIL stream_count: got %0d want %0d (max 3)", count, q_data.size());
         end
      end
      checks++; if (out_idx != 1000) begin errors++; $display("FAIL stream_total: got %0d want 1000", out_idx); end
      checks++; if (first_pop != start + 3) begin errors++; $display("FAIL stream_first: got cycle %0d want %0d", first_pop, start + 3); end
      checks++; if (last_pop_cyc != start + 1002) begin errors++; $display("FAIL stream_rate: last at %0d want %0d", last_pop_cyc, start + 1002); end
   endtask

   task automatic test_full_wrap();
      int accepted, n_pop, n_bad;
      for (int round = 0; round < 3; round++) begin
         accepted = 0;
         for (int k = 0; k < 40 && in_ready === 1'b1; k++) begin
            step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
            if (last_push) accepted++;
            checks++;
            if (almost_full !== (q_data.size() >= AF_LEVEL)) begin
               errors++; $display("FAIL fill_almost_full: got %b at occupancy %0d", almost_full, q_data.size());
            end
         end
         repeat (3) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
         checks++; if (accepted != CAP) begin errors++; $display("FAIL full_accepted: got %0d want %0d", accepted, CAP); end
         checks++; if (count !== CNT_W'(CAP)) begin errors++; $display("FAIL full_count: got %0d want %0d", count, CAP); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
         checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL full_almost_full: got %b want 1", almost_full); end
         drain(60, n_pop, n_bad);
         checks++; if (n_pop != CAP || n_bad != 0) begin errors++; $display("FAIL wrap_drain round %0d: popped %0d bad %0d want %0d/0", round, n_pop, n_bad, CAP); end
         checks++; if (count !== '0 || out_valid !== 1'b0 || almost_full !== 1'b0) begin
            errors++; $display("FAIL wrap_empty: count %0d valid %b af %b want 0/0/0", count, out_valid, almost_full);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic ok;
      int   n_pop, n_bad;
      step(1'b1, 16'h003C, 1'b0, 1'b0);
      wait_valid(10, ok);
      checks++; if (!ok || count !== CNT_W'(1)) begin errors++; $display("FAIL simul_setup: valid %b count %0d want 1/1", ok, count); end
      step(1'b1, 16'h005A, 1'b1, 1'b0);
      checks++; if (!last_push || !last_pop || pop_act !== 16'h003C) begin
         errors++; $display("FAIL simul_both: push %b pop %b data %h want 1/1/003c", last_push, last_pop, pop_act);
      end
      checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL simul_count: got %0d want 1", count); end
      drain(20, n_pop, n_bad);
      checks++; if (n_pop != 1 || n_bad != 0) begin errors++; $display("FAIL simul_drain: popped %0d bad %0d want 1/0", n_pop, n_bad); end

      for (int k = 0; k < 40 && in_ready === 1'b1; k++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      checks++; if (in_ready !== 1'b0 || count !== CNT_W'(CAP)) begin errors++; $display("FAIL full_setup: ready %b count %0d want 0/%0d", in_ready, count, CAP); end
      step(1'b1, 16'h1111, 1'b1, 1'b0);
      checks++; if (last_push || !last_pop) begin errors++; $display("FAIL full_pop: push %b pop %b want 0/1", last_push, last_pop); end
      checks++; if (in_ready !== 1'b1 || count !== CNT_W'(CAP - 1)) begin
         errors++; $display("FAIL full_ready_rise: ready %b count %0d want 1/%0d", in_ready, count, CAP - 1);
      end
      step(1'b1, 16'h2222, 1'b0, 1'b0);
      checks++; if (!last_push || count !== CNT_W'(CAP) || in_ready !== 1'b0) begin
         errors++; $display("FAIL full_refill: push %b count %0d ready %b want 1/%0d/0", last_push, count, in_ready, CAP);
      end
      drain(60, n_pop, n_bad);
      checks++; if (n_pop != CAP || n_bad != 0 || count !== '0) begin
         errors++; $display("FAIL full_drain: popped %0d bad %0d count %0d want %0d/0/0", n_pop, n_bad, count, CAP);
      end
   endtask

   task automatic test_flush();
      logic ok;
      for (int k = 0; k < 11; k++) step(1'b1, WIDTH'(16'h0100 + k), 1'b0, 1'b0);
      repeat (3) step(1'b0, '0, 1'b0, 1'b0);
      checks++; if (count !== CNT_W'(11)) begin errors++; $display("FAIL flush_setup: count %0d want 11", count); end
      step(1'b0, '0, 1'b1, 1'b0);
      checks++; if (!last_pop || pop_act !== 16'h0100 || count !== CNT_W'(10)) begin
         errors++; $display("FAIL flush_pop: pop %b data %h count %0d want 1/0100/10", last_pop, pop_act, count);
      end
      step(1'b1, 16'hDEAD, 1'b1, 1'b1);
      checks++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || almost_full !== 1'b0) begin
         errors++; $display("FAIL flush_clear: count %0d valid %b ready %b af %b want 0/0/1/0", count, out_valid, in_ready, almost_full);
      end
      step(1'b1, 16'h0001, 1'b0, 1'b0);
      wait_valid(8, ok);
      checks++; if (!ok || out_data !== 16'h0001 || count !== CNT_W'(1)) begin
         errors++; $display("FAIL flush_new: valid %b data %h count %0d want 1/0001/1", ok, out_data, count);
      end
      step(1'b0, '0, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (out_valid !== 1'b0 || count !== '0) begin
            errors++; $display("FAIL flush_stale: valid %b data %h count %0d want 0/-/0", out_valid, out_data, count);
         end
         step(1'b0, '0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_random();
      logic exp_v;
      int   n_pop, n_bad;
      for (int k = 0; k < 10000; k++) begin
         step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         if (last_pop) begin
            checks++;
            if (pop_act !== pop_exp) begin errors++; $display("FAIL rand_data cycle %0d: got %h want %h", step_cyc, pop_act, pop_exp); end
         end
         exp_v = 1'b0;
         if (q_data.size() > 0) exp_v = (q_time[0] + 3 <= cyc);
         checks++;
         if (count !== CNT_W'(q_data.size())) begin errors++; $display("FAIL rand_count cycle %0d: got %0d want %0d", cyc, count, q_data.size()); end
         checks++;
         if (out_valid !== exp_v) begin errors++; $display("FAIL rand_out_valid cycle %0d: got %b want %b", cyc, out_valid, exp_v); end
         checks++;
         if (almost_full !== (q_data.size() >= AF_LEVEL)) begin errors++; $display("FAIL rand_almost_full cycle %0d: got %b at %0d", cyc, almost_full, q_data.size()); end
         if (q_data.size() < DEPTH) begin
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL rand_in_ready cycle %0d: got %b at %0d", cyc, in_ready, q_data.size()); end
         end
      end
      drain(100, n_pop, n_bad);
      checks++; if (n_bad != 0 || q_data.size() != 0 || count !== '0) begin
         errors++; $display("FAIL rand_drain: bad %0d left %0d count %0d want 0/0/0", n_bad, q_data.size(), count);
      end
   endtask

   initial begin
      test_reset();
      test_first_word();
      test_streaming();
      test_full_wrap();
      test_simultaneous();
      test_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
